// File: rtl/apb_arbiter.sv
// Round-robin arbiter that funnels NREQ requester slots onto a single APB master port.
// Each requester owns one capture slot; the FSM serves one slot at a time.

module apb_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NREQ-1:0]    i_req_start,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    input  logic [NREQ-1:0]    i_req_write,
    output logic [NREQ-1:0]    o_req_busy,
    output logic [NREQ-1:0]    o_req_done,
    output logic [DW-1:0]      o_req_rdata,
    output logic               o_req_slverr,
    output logic [NREQ-1:0]    o_grant,
    output logic               o_m_start,
    output logic [AW-1:0]      o_m_addr,
    output logic [DW-1:0]      o_m_wdata,
    output logic               o_m_write,
    input  logic               i_m_done,
    input  logic [DW-1:0]      i_m_rdata,
    input  logic               i_m_slverr
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [NREQ-1:0]           busy_q, busy_d;
    logic [NREQ-1:0][AW-1:0]   addr_q, addr_d;
    logic [NREQ-1:0][DW-1:0]   wdata_q, wdata_d;
    logic [NREQ-1:0]           write_q, write_d;
    logic [NREQ-1:0]           grant_q, grant_d;
    logic [IW-1:0]             gidx_q, gidx_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]           done_q, done_d;
    logic [DW-1:0]             rdata_q, rdata_d;
    logic                      slverr_q, slverr_d;

    logic                      pick_vld;
    logic [IW-1:0]             pick_idx;
    logic [IW-1:0]             cand;
    logic                      owned;

    // Index arithmetic modulo NREQ, which need not be a power of two.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scanning from the far end lets the candidate closest to rr_ptr win last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = wrap_idx(rr_ptr_q, k);
            if (busy_q[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;

        // A start on a slot that is already pending is dropped without touching the slot.
        for (int n = 0; n < NREQ; n++) begin
            if (i_req_start[n] && !busy_q[n]) begin
                busy_d[n]  = 1'b1;
                addr_d[n]  = i_req_addr[n*AW +: AW];
                wdata_d[n] = i_req_wdata[n*DW +: DW];
                write_d[n] = i_req_write[n];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_m_done) begin
                    done_d[gidx_q] = 1'b1;
                    rdata_d        = i_m_rdata;
                    slverr_d       = i_m_slverr;
                    busy_d[gidx_q] = 1'b0;
                    grant_d        = '0;
                    rr_ptr_d       = wrap_idx(gidx_q, 1);
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            busy_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= '0;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    // The master-side bus is driven only while a slot owns it, zero otherwise.
    assign owned        = (state_q != S_IDLE);
    assign o_m_start    = (state_q == S_ISSUE);
    assign o_m_addr     = owned ? addr_q[gidx_q]  : '0;
    assign o_m_wdata    = owned ? wdata_q[gidx_q] : '0;
    assign o_m_write    = owned ? write_q[gidx_q] : 1'b0;
    assign o_grant      = grant_q;
    assign o_req_busy   = busy_q;
    assign o_req_done   = done_q;
    assign o_req_rdata  = rdata_q;
    assign o_req_slverr = slverr_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.

module tb_apb_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               i_clk;
    logic               i_reset_n;
    logic [NREQ-1:0]    i_req_start;
    logic [NREQ*AW-1:0] i_req_addr;
    logic [NREQ*DW-1:0] i_req_wdata;
    logic [NREQ-1:0]    i_req_write;
    logic [NREQ-1:0]    o_req_busy;
    logic [NREQ-1:0]    o_req_done;
    logic [DW-1:0]      o_req_rdata;
    logic               o_req_slverr;
    logic [NREQ-1:0]    o_grant;
    logic               o_m_start;
    logic [AW-1:0]      o_m_addr;
    logic [DW-1:0]      o_m_wdata;
    logic               o_m_write;
    logic               i_m_done;
    logic [DW-1:0]      i_m_rdata;
    logic               i_m_slverr;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int dut_order[$];
    int n_mstart   = 0;
    int n_done0    = 0;
    int n_done_all = 0;

    logic [AW-1:0] sv_addr;
    logic [DW-1:0] sv_wdata;
    logic          sv_write;

    // Model: pending slots, current owner (-1 none), whether its start was already issued.
    bit   [NREQ-1:0] mb;
    logic [AW-1:0]   ma  [NREQ];
    logic [DW-1:0]   mwd [NREQ];
    bit              mwr [NREQ];
    int              rr;
    int              owner;
    bit              issued;
    bit   [NREQ-1:0] mdone;
    logic [DW-1:0]   mrd;
    bit              merr;

    apb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_req_start  (i_req_start),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_write  (i_req_write),
        .o_req_busy   (o_req_busy),
        .o_req_done   (o_req_done),
        .o_req_rdata  (o_req_rdata),
        .o_req_slverr (o_req_slverr),
        .o_grant      (o_grant),
        .o_m_start    (o_m_start),
        .o_m_addr     (o_m_addr),
        .o_m_wdata    (o_m_wdata),
        .o_m_write    (o_m_write),
        .i_m_done     (i_m_done),
        .i_m_rdata    (i_m_rdata),
        .i_m_slverr   (i_m_slverr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        mb = '0;
        for (int n = 0; n < NREQ; n++) begin
            ma[n] = '0; mwd[n] = '0; mwr[n] = 1'b0;
        end
        rr = 0; owner = -1; issued = 1'b0;
        mdone = '0; mrd = '0; merr = 1'b0;
    endtask

    task automatic model_step();
        bit [NREQ-1:0] ob;
        int j;
        ob = mb;
        mdone = '0;
        if (owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (rr + k) % NREQ;
                if (ob[j]) begin
                    owner  = j;
                    issued = 1'b0;
                    break;
                end
            end
        end else if (!issued) begin
            issued = 1'b1;
        end else if (i_m_done) begin
            mdone[owner] = 1'b1;
            mrd  = i_m_rdata;
            merr = i_m_slverr;
            mb[owner] = 1'b0;
            rr = (owner + 1) % NREQ;
            owner = -1;
        end
        for (int n = 0; n < NREQ; n++) begin
            if (i_req_start[n] && !ob[n]) begin
                mb[n]  = 1'b1;
                ma[n]  = i_req_addr[n*AW +: AW];
                mwd[n] = i_req_wdata[n*DW +: DW];
                mwr[n] = i_req_write[n];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or negedge i_reset_n);
            if (!i_reset_n) model_reset();
            else model_step();
        end
    end

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int n = 0; n < NREQ; n++) if (v[n]) return n;
        return -1;
    endfunction

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge i_clk);
        chk("busy",    o_req_busy,   mb);
        chk("grant",   o_grant,      (owner >= 0) ? (NREQ'(1) << owner) : NREQ'(0));
        chk("m_start", o_m_start,    (owner >= 0) && !issued);
        chk("m_addr",  o_m_addr,     (owner >= 0) ? ma[owner] : '0);
        chk("m_wdata", o_m_wdata,    (owner >= 0) ? mwd[owner] : '0);
        chk("m_write", o_m_write,    (owner >= 0) ? mwr[owner] : 1'b0);
        chk("done",    o_req_done,   mdone);
        chk("rdata",   o_req_rdata,  mrd);
        chk("slverr",  o_req_slverr, merr);
        if (o_m_start === 1'b1) begin
            n_mstart++;
            dut_order.push_back(onehot_idx(o_grant));
        end
        if (o_req_done[0] === 1'b1) n_done0++;
        n_done_all += $countones(o_req_done);
    end

    task automatic set_slot(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        i_req_addr[n*AW +: AW]  = a;
        i_req_wdata[n*DW +: DW] = d;
        i_req_write[n]          = w;
    endtask

    task automatic pulse_start(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        set_slot(n, a, d, w);
        i_req_start = '0;
        i_req_start[n] = 1'b1;
        @(negedge i_clk);
        i_req_start = '0;
    endtask

    task automatic wait_mstart();
        int g;
        g = 0;
        while (o_m_start !== 1'b1 && g < 40) begin
            @(negedge i_clk);
            g++;
        end
        if (o_m_start !== 1'b1) begin
            n_total++;
            $display("FAIL wait_mstart: no o_m_start within 40 cycles (cycle %0d)", cyc);
        end else begin
            sv_addr  = o_m_addr;
            sv_wdata = o_m_wdata;
            sv_write = o_m_write;
        end
    endtask

    task automatic serve(input int lat, input logic [DW-1:0] rd, input logic err, input logic [NREQ-1:0] also);
        wait_mstart();
        repeat (lat) @(negedge i_clk);
        i_m_done   = 1'b1;
        i_m_rdata  = rd;
        i_m_slverr = err;
        if (also != '0) i_req_start = also;
        @(negedge i_clk);
        i_m_done   = 1'b0;
        i_m_rdata  = '0;
        i_m_slverr = 1'b0;
        if (also != '0) i_req_start = '0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (o_req_busy != '0 && g < 10) begin
            serve(1, '0, 1'b0, '0);
            g++;
        end
    endtask

    task automatic apply_reset();
        i_reset_n = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    int fair_exp[5] = '{0, 1, 2, 3, 0};
    int base;
    int ms0, dn0, dall;

    initial begin
        i_req_start = '0; i_req_addr = '0; i_req_wdata = '0; i_req_write = '0;
        i_m_done = 1'b0; i_m_rdata = '0; i_m_slverr = 1'b0;
        i_reset_n = 1'b1;
        #1 i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_busy",  o_req_busy, 4'b0000);
        chk("rst_grant", o_grant, 4'b0000);
        chk("rst_start", o_m_start, 1'b0);
        chk("rst_rdata", o_req_rdata, 32'h0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Single write from requester 0
        pulse_start(0, 32'h10, 32'hA5A5A5A5, 1'b1);
        chk("single_busy_t1",  o_req_busy, 4'b0001);
        chk("single_start_t1", o_m_start, 1'b0);
        @(negedge i_clk);
        chk("single_start_t2", o_m_start, 1'b1);
        chk("single_addr",     o_m_addr, 32'h10);
        chk("single_wdata",    o_m_wdata, 32'hA5A5A5A5);
        chk("single_write",    o_m_write, 1'b1);
        chk("single_grant",    o_grant, 4'b0001);
        @(negedge i_clk);
        chk("single_start_off", o_m_start, 1'b0);
        chk("single_done_d",    o_req_done, 4'b0000);
        i_m_done = 1'b1;
        @(negedge i_clk);
        i_m_done = 1'b0;
        chk("single_done_d1",  o_req_done, 4'b0001);
        chk("single_busy_clr", o_req_busy, 4'b0000);
        chk("single_grant0",   o_grant, 4'b0000);
        @(negedge i_clk);
        chk("single_done_pulse", o_req_done, 4'b0000);

        // Contention from rr_ptr = 0
        apply_reset();
        base = dut_order.size();
        set_slot(1, 32'h1100, 32'h11, 1'b1);
        set_slot(3, 32'h3300, 32'h33, 1'b0);
        i_req_start = 4'b1010;
        @(negedge i_clk);
        i_req_start = '0;
        serve(1, 32'h1, 1'b0, '0);
        serve(1, 32'h3, 1'b0, '0);
        chk("cont_count",  dut_order.size() - base, 2);
        chk("cont_first",  dut_order[base], 1);
        chk("cont_second", dut_order[base+1], 3);

        // Fairness with continuous re-requests
        base = dut_order.size();
        for (int n = 0; n < NREQ; n++) set_slot(n, 32'h200 + n, 32'h50 + n, n[0]);
        i_req_start = '1;
        for (int i = 0; i < 5; i++) serve(1, 32'h100 + i, 1'b0, '0);
        i_req_start = '0;
        drain();
        for (int i = 0; i < 5; i++) chk("fair_order", dut_order[base+i], fair_exp[i]);

        // Read with slave error, held until the next completion
        pulse_start(2, 32'h20, 32'h0, 1'b0);
        serve(2, 32'hDEADBEEF, 1'b1, '0);
        chk("rderr_rdata",  o_req_rdata, 32'hDEADBEEF);
        chk("rderr_slverr", o_req_slverr, 1'b1);
        repeat (3) @(negedge i_clk);
        pulse_start(1, 32'h24, 32'hCAFE0001, 1'b1);
        chk("rderr_hold_rdata",  o_req_rdata, 32'hDEADBEEF);
        chk("rderr_hold_slverr", o_req_slverr, 1'b1);
        serve(1, 32'h12345678, 1'b0, '0);
        chk("wr_load_rdata",  o_req_rdata, 32'h12345678);
        chk("wr_load_slverr", o_req_slverr, 1'b0);

        // Duplicate starts on a busy requester, including one coincident with done
        repeat (2) @(negedge i_clk);
        ms0 = n_mstart;
        dn0 = n_done0;
        pulse_start(0, 32'h40, 32'h4040, 1'b1);
        pulse_start(0, 32'h44, 32'h4444, 1'b0);
        serve(1, 32'h0BADF00D, 1'b0, 4'b0001);
        chk("dup_addr",  sv_addr, 32'h40);
        chk("dup_write", sv_write, 1'b1);
        repeat (5) @(negedge i_clk);
        chk("dup_mstart_cnt", n_mstart - ms0, 1);
        chk("dup_done_cnt",   n_done0 - dn0, 1);
        chk("dup_busy",       o_req_busy, 4'b0000);

        // Reset in the middle of WAIT
        pulse_start(3, 32'h30, 32'h3030, 1'b1);
        wait_mstart();
        repeat (2) @(negedge i_clk);
        dall = n_done_all;
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        chk("mid_rst_busy",   o_req_busy, 4'b0000);
        chk("mid_rst_grant",  o_grant, 4'b0000);
        chk("mid_rst_addr",   o_m_addr, 32'h0);
        chk("mid_rst_rdata",  o_req_rdata, 32'h0);
        chk("mid_rst_slverr", o_req_slverr, 1'b0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        i_m_done = 1'b1; i_m_rdata = 32'hFFFFFFFF; i_m_slverr = 1'b1;
        @(negedge i_clk);
        i_m_done = 1'b0; i_m_rdata = '0; i_m_slverr = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("stray_done_cnt", n_done_all - dall, 0);
        chk("stray_rdata",    o_req_rdata, 32'h0);
        chk("stray_busy",     o_req_busy, 4'b0000);

        repeat (2) @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL take parameter NREQ, default 4, meaning the number of requesters (range 2..8).
REQ-002 The block SHALL take parameter AW, default 32, meaning the address width.
REQ-003 The block SHALL take parameter DW, default 32, meaning the data width.
REQ-004 The block SHALL have these ports, clock and reset first:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset_n  in  1  reset; asynchronous, active-low
- i_req_start  in  NREQ  per-requester transaction start pulse
- i_req_addr  in  NREQ*AW  per-requester address; slot n at [n*AW +: AW]
- i_req_wdata  in  NREQ*DW  per-requester write data; slot n at [n*DW +: DW]
- i_req_write  in  NREQ  per-requester direction; 1 = write
- o_req_busy  out  NREQ  per-requester request pending
- o_req_done  out  NREQ  per-requester completion pulse
- o_req_rdata  out  DW  read data of the last completed transaction
- o_req_slverr  out  1  slave error of the last completed transaction
- o_grant  out  NREQ  one-hot current owner; 0 when idle
- o_m_start  out  1  start pulse to the APB master
- o_m_addr  out  AW  address to the APB master
- o_m_wdata  out  DW  write data to the APB master
- o_m_write  out  1  direction to the APB master
- i_m_done  in  1  APB master completion pulse
- i_m_rdata  in  DW  APB master read data
- i_m_slverr  in  1  APB master slave error

Function
REQ-005 If i_req_start[n]=1 and o_req_busy[n]=0, the block SHALL capture addr/wdata/write of slot n and set o_req_busy[n] on the next edge.
REQ-006 If i_req_start[n]=1 while o_req_busy[n]=1, the block SHALL ignore it with no state change.
REQ-007 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-008 In IDLE with any busy bit set, the block SHALL grant round-robin: the first busy index at or after rr_ptr, wrapping NREQ-1 to 0.
REQ-009 On the grant, the block SHALL set o_grant one-hot and go to ISSUE.
REQ-010 In ISSUE, o_m_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-011 o_m_addr, o_m_wdata and o_m_write SHALL carry the granted slot's captured values from ISSUE through the cycle i_m_done is sampled.
REQ-012 In WAIT, on i_m_done=1 for owner g, on the next edge the block SHALL:
- pulse o_req_done[g] for one cycle;
- load o_req_rdata from i_m_rdata and o_req_slverr from i_m_slverr;
- clear o_req_busy[g] and o_grant;
- set rr_ptr to (g+1) mod NREQ;
- return to IDLE.
REQ-013 i_m_done outside WAIT SHALL be ignored.
REQ-014 o_req_rdata and o_req_slverr SHALL hold until the next completion; a write completion SHALL also load them.
REQ-015 Latency SHALL be: start at cycle t, busy at t+1, o_m_start at t+2 when uncontended; i_m_done at cycle d, o_req_done at d+1, next o_m_start no earlier than d+2.
REQ-016 If i_req_start[g] and i_m_done arrive in the same cycle, the start SHALL be ignored (REQ-006).
REQ-017 A new start from another requester during ISSUE/WAIT SHALL be captured and served after the current transaction.
REQ-018 At most one bit of o_grant and o_req_done SHALL be set in any cycle.
REQ-019 No requester SHALL wait more than NREQ-1 other transactions.

Reset
REQ-020 When i_reset_n=0, the block SHALL immediately force the state to IDLE, rr_ptr to 0, all busy bits to 0 and all outputs to 0, including captured slots.
REQ-021 Reset mid-transaction SHALL discard all pending requests without any o_req_done pulse.
REQ-022 A later stray i_m_done after reset SHALL be ignored (REQ-013).

Verification
REQ-023 The bench SHALL cover these scenarios:
- Single: req0 write, addr 0x10, data 0xA5A5A5A5 -> o_m_start at t+2 with those values; i_m_done at d -> o_req_done[0] at d+1, busy[0]=0.
- Contention: req1 and req3 start in the same cycle, rr_ptr=0 -> req1 served first, then req3; rr_ptr ends at 0.
- Fairness: all 4 requesters re-request continuously -> grant order 0,1,2,3,0 and no starvation.
- Read error: req2 read, i_m_rdata 0xDEADBEEF, i_m_slverr=1 -> o_req_rdata=0xDEADBEEF, o_req_slverr=1, held until the next completion.
- Duplicate start: req0 pulses again while busy -> ignored; exactly one o_m_start and one o_req_done[0].
- Reset mid-WAIT: reset asserted -> outputs 0 immediately; no o_req_done; stray i_m_done ignored.
